// File: rtl/moore_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : moore_fsm
//  Description : Moore serial sequence detector for the bit pattern 1011.
//                One bit of IN is sampled on every rising CLOCK edge; OUT is
//                a pure decode of the state register and is high for exactly
//                one cycle after each detected pattern.
//
//  Ports
//      OUT    output  1  detect flag, high only in state S1011
//      IN     input   1  serial data bit, sampled on rising CLOCK
//      CLOCK  input   1  clock, rising-edge active
//      RESET  input   1  synchronous active-high reset, forces IDLE
//
//  Configuration
//      MOORE_OVERLAP_EN  when defined, the trailing "1" of a match may start
//                        the next match (S1011 on 0 goes to S10 instead of
//                        IDLE). Undefined by default: non-overlapping.
//
//  Revision    : 1.0  initial release
// ============================================================================
module moore_fsm (
    output logic OUT,
    input  logic IN,
    input  logic CLOCK,
    input  logic RESET
);

    // ------------------------------------------------------------------
    // State encoding (3-bit binary; codes 5..7 are unused)
    // ------------------------------------------------------------------
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S10   = 3'd2;
    localparam logic [2:0] S101  = 3'd3;
    localparam logic [2:0] S1011 = 3'd4;

    // State S1011 leaving on IN=0 depends on the overlap build option.
`ifdef MOORE_OVERLAP_EN
    localparam logic [2:0] C_S1011_ON_ZERO = S10;
`else
    localparam logic [2:0] C_S1011_ON_ZERO = IDLE;
`endif

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    // ------------------------------------------------------------------
    // State register. RESET has priority over any transition, so an
    // unknown IN while RESET is high never reaches the state.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = IN ? S1    : IDLE;
            S1:      w_next_state = IN ? S1    : S10;
            S10:     w_next_state = IN ? S101  : IDLE;
            // "1010" still ends in the prefix "10"
            S101:    w_next_state = IN ? S1011 : S10;
            S1011:   w_next_state = IN ? S1    : C_S1011_ON_ZERO;
            // Unused encodings recover to IDLE on the next edge
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: depends on the state register only
    // ------------------------------------------------------------------
    always_comb begin
        OUT = 1'b0;
        if (r_state == S1011) begin
            OUT = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_moore_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore_fsm
//  Description : Self-checking bench for moore_fsm. A driver applies IN and
//                RESET on the falling edge and pushes the expected OUT for
//                the following rising edge into a queue; a monitor pops and
//                compares one entry per cycle. The reference model keeps the
//                bit history since reset (or since the last match in the
//                non-overlapping build) and flags a match whenever that
//                history ends in 1011.
//
//  Configuration
//      MOORE_OVERLAP_EN  must match the build of the design under test.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_moore_fsm;

`ifdef MOORE_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic din = 1'b0;
    logic reset = 1'b0;
    logic dout;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int cycle = 0;

    bit exp_q[$];
    bit hist[$];

    always #5 clk = ~clk;

    moore_fsm dut (
        .OUT   (dout),
        .IN    (din),
        .CLOCK (clk),
        .RESET (reset)
    );

    // ------------------------------------------------------------------
    // Monitor: one expected value per rising edge once stimulus started
    // ------------------------------------------------------------------
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dout !== e) begin
                    errors++;
                    $display("FAIL out_check cycle %0d: OUT=%b expected %b", cycle, dout, e);
                end
                if (dout === 1'b1) pulse_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver + reference model
    // ------------------------------------------------------------------
    task automatic step(input logic b, input logic r);
        bit e;
        @(negedge clk);
        din   = b;
        reset = r;
        e     = 1'b0;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() >= 4)
                e = (hist[hist.size()-4] == 1'b1) && (hist[hist.size()-3] == 1'b0) &&
                    (hist[hist.size()-2] == 1'b1) && (hist[hist.size()-1] == 1'b1);
            if (e && !OVERLAP) hist.delete();
            while (hist.size() > 4) void'(hist.pop_front());
        end
        exp_q.push_back(e);
    endtask

    // Feed n bits of v, most significant (first in time) bit first
    task automatic feed(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic do_reset();
        step(1'bx, 1'b1);
    endtask

    // Wait (bounded) until every expected value has been compared
    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic check_pulses(input string name, input int expected);
        drain();
        checks++;
        if (pulse_cnt != expected) begin
            errors++;
            $display("FAIL %s: pulses=%0d expected %0d", name, pulse_cnt, expected);
        end
        pulse_cnt = 0;
    endtask

    initial begin
        // Reset with IN unknown, then idle zeros
        do_reset();
        feed(32'b000, 3);
        check_pulses("reset_idle", 0);

        // Basic detect: 0,0,1,1,0,0,1,0,1,1
        do_reset();
        pulse_cnt = 0;
        feed(32'b0011001011, 10);
        check_pulses("basic_detect", 1);

        // Prefix recovery: 1,0,1,0,1,1
        do_reset();
        feed(32'b101011, 6);
        check_pulses("prefix_recovery", 1);

        // Overlap: 1,0,1,1,0,1,1
        do_reset();
        feed(32'b1011011, 7);
        check_pulses("overlap", OVERLAP ? 2 : 1);

        // Reset mid-pattern, then 1 must leave the FSM in S1: 1,0,1,R,1
        do_reset();
        feed(32'b101, 3);
        do_reset();
        feed(32'b1, 1);
        check_pulses("reset_mid", 0);
        // From S1, 0,1,1 completes 1011
        feed(32'b011, 3);
        check_pulses("after_reset_s1", 1);

        // Reset asserted on the edge that would complete the pattern
        do_reset();
        feed(32'b101, 3);
        step(1'b1, 1'b1);
        check_pulses("reset_on_final_bit", 0);

        // Reset while in S1011
        do_reset();
        feed(32'b1011, 4);
        do_reset();
        feed(32'b0, 1);
        check_pulses("reset_in_match", 1);

        // Long stream: single pulse after bit 29
        do_reset();
        feed(32'h3293_1C5D, 32);
        check_pulses("long_stream", 1);

        // Randomized stream with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0)
                do_reset();
            else
                step(1'($urandom_range(0, 1)), 1'b0);
        end
        drain();
        pulse_cnt = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moore_fsm.md
# moore_fsm

Moore-type serial sequence detector for the bit pattern 1011, sampling one bit per clock on `IN`. `OUT` is a function of the current state only and pulses high for one cycle after each detected pattern. The block is a self-contained control-path primitive for single-bit serial streams. Port order in positional instantiation is `OUT, IN, CLOCK, RESET`.

## Interface
- No parameters. The pattern (1011) and the state encoding are fixed.
- `CLOCK`  input  1  single clock; all state changes occur on its rising edge.
- `RESET`  input  1  reset, synchronous and active-high; sampled on the rising edge of `CLOCK`.
- `IN`  input  1  serial data bit, sampled on each rising edge of `CLOCK`.
- `OUT`  output  1  detect flag; high only while the FSM is in state `S1011`.

## Operation
- Five states, binary-encoded in a 3-bit state register:
  - `IDLE`: no prefix matched.
  - `S1`: matched "1".
  - `S10`: matched "10".
  - `S101`: matched "101".
  - `S1011`: full match.
- Transitions, evaluated at each rising edge with `RESET`=0 (IN=0 / IN=1):
  - `IDLE`: 0 → `IDLE`, 1 → `S1`.
  - `S1`: 0 → `S10`, 1 → `S1`.
  - `S10`: 0 → `IDLE`, 1 → `S101`.
  - `S101`: 0 → `S10`, 1 → `S1011`.
  - `S1011`: 1 → `S1`; 0 → `S10` if `MOORE_OVERLAP_EN` is defined, otherwise `IDLE`.
- Unused encodings (5–7) go to `IDLE` on the next edge, with `OUT`=0.
- `OUT` decode: 1 in `S1011`, 0 in every other state. `OUT` is driven from a register (or a pure decode of the state register) and never depends combinationally on `IN`.
- `RESET`=1 at a rising edge sets state to `IDLE` regardless of `IN` or the current state, including mid-pattern and while in `S1011`. `RESET` takes priority over all transitions.

## Timing
- Reset value: state `IDLE`, `OUT`=0, starting from the first rising edge at which `RESET`=1.
- Before the first reset edge, state and `OUT` are undefined. The bench must assert reset before checking.
- Latency: when the final "1" of the pattern is sampled at edge N, `OUT`=1 during the cycle from edge N to edge N+1.
- `OUT` is high for exactly one cycle per detection, because `S1011` always exits on the next edge.
- Back-to-back detections are possible only in overlap mode, with a minimum spacing of 3 cycles (1011011).
- While `RESET`=1, `IN` is don't-care; X on `IN` must not propagate into the state register.
- `IN` must be stable around the rising edge. The bench changes `IN` on the falling edge.

## Configuration
- `MOORE_OVERLAP_EN`, defined: overlapping detection. The trailing "1" of a match can start a new match (`S1011` with IN=0 → `S10`). The stream 1011011 produces two pulses.
- `MOORE_OVERLAP_EN`, undefined (default): non-overlapping detection. `S1011` with IN=0 → `IDLE`. The stream 1011011 produces one pulse.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `RESET`=1 for one edge with `IN`=X → `OUT`=0 and state `IDLE`. Then feed `IN`=0 for 3 cycles → `OUT` stays 0.
- Basic detect: after reset, feed 0,0,1,1,0,0,1,0,1,1 → `OUT` is 0 throughout, except one 1-cycle pulse in the cycle after the final 1 is sampled.
- Prefix recovery: feed 1,0,1,0,1,1 → exactly one pulse, following the last bit (`S101` with 0 → `S10` retains the prefix).
- Overlap: feed 1,0,1,1,0,1,1.
  - With `MOORE_OVERLAP_EN` defined → pulses after bit 4 and after bit 7.
  - With it undefined → a pulse after bit 4 only.
- Reset mid-operation: feed 1,0,1, assert `RESET` for one edge, then feed 1 → no pulse; state `IDLE` then `S1`.
- Long stream: feed 0,0,1,1,0,0,1,0,1,0,0,1,0,0,1,1,0,0,0,1,1,1,0,0,0,1,0,1,1,1,0,1 → exactly one pulse, in the cycle after bit 29 (1-based) is sampled.
